// File: rtl/csr_req_scheduler.sv
// Round-robin front end for the single CSR execution unit: one request is held at a time,
// and FPU CSR accesses wait for the target warp to drain before being issued.
module csr_req_scheduler #(
  parameter int                NUM_REQS  = 4,
  parameter int                WID_W     = 2,
  parameter int                ADDR_W    = 12,
  parameter int                DATAW     = 64,
  parameter logic [ADDR_W-1:0] FCSR_ADDR = ADDR_W'(3),
  parameter int                IDX_W     = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*WID_W-1:0] req_wid,
  input  logic [NUM_REQS*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic [WID_W-1:0]          alm_empty_wid,
  input  logic                      alm_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WID_W-1:0]          out_wid,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATAW-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      unlock_valid,
  output logic [WID_W-1:0]          unlock_wid,
  output logic [31:0]               drain_stalls
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [WID_W-1:0]    hold_wid_p1;
  logic [ADDR_W-1:0]   hold_addr_p1;
  logic [DATAW-1:0]    hold_data_p1;
  logic [IDX_W-1:0]    hold_idx_p1;
  logic                is_fpu_p1;
  logic [31:0]         stall_cnt_p1;

  logic                grant_found_p0;
  logic [IDX_W-1:0]    grant_idx_p0;
  logic [WID_W-1:0]    sel_wid_p0;
  logic [ADDR_W-1:0]   sel_addr_p0;
  logic [DATAW-1:0]    sel_data_p0;
  logic                sel_fpu_p0;
  logic [IDX_W-1:0]    rr_next_p0;

  // Stage p0: round-robin search starting at rr_ptr, then mux out the winner's fields
  always_comb begin
    grant_found_p0 = 1'b0;
    grant_idx_p0   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      int j;
      j = (int'(rr_ptr) + i) % NUM_REQS;
      if (!grant_found_p0 && req_valid[j]) begin
        grant_found_p0 = 1'b1;
        grant_idx_p0   = IDX_W'(j);
      end
    end
    sel_wid_p0  = req_wid[grant_idx_p0*WID_W +: WID_W];
    sel_addr_p0 = req_addr[grant_idx_p0*ADDR_W +: ADDR_W];
    sel_data_p0 = req_data[grant_idx_p0*DATAW +: DATAW];
    sel_fpu_p0  = (sel_addr_p0 <= FCSR_ADDR);
    rr_next_p0  = (int'(grant_idx_p0) == NUM_REQS - 1) ? '0 : grant_idx_p0 + IDX_W'(1);
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_found_p0)
      req_ready = NUM_REQS'(1) << grant_idx_p0;
  end

  // Stage p1: hold register plus control FSM; reset clears everything so a held request is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      hold_wid_p1  <= '0;
      hold_addr_p1 <= '0;
      hold_data_p1 <= '0;
      hold_idx_p1  <= '0;
      is_fpu_p1    <= 1'b0;
      stall_cnt_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found_p0) begin
            hold_wid_p1  <= sel_wid_p0;
            hold_addr_p1 <= sel_addr_p0;
            hold_data_p1 <= sel_data_p0;
            hold_idx_p1  <= grant_idx_p0;
            is_fpu_p1    <= sel_fpu_p0;
            rr_ptr       <= rr_next_p0;
            state        <= sel_fpu_p0 ? DRAIN : SEND;
          end
        end
        DRAIN: begin
          if (alm_empty)
            state <= SEND;
          else
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
        SEND: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid     = !reset && (state == SEND);
  assign out_wid       = hold_wid_p1;
  assign out_addr      = hold_addr_p1;
  assign out_data      = hold_data_p1;
  assign out_idx       = hold_idx_p1;
  assign alm_empty_wid = hold_wid_p1;
  assign unlock_valid  = out_valid && out_ready && is_fpu_p1;
  assign unlock_wid    = hold_wid_p1;
  assign drain_stalls  = stall_cnt_p1;

endmodule

// File: tb/tb_csr_req_scheduler.sv
// Directed bench for csr_req_scheduler: a cycle table for arbitration, then hand-written
// sequences for FPU drain, boundary address, backpressure, reset and counter saturation.
module tb_csr_req_scheduler;
  localparam int NR = 4;
  localparam int WW = 2;
  localparam int AW = 12;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*WW-1:0]  req_wid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [WW-1:0]     alm_empty_wid;
  logic              alm_empty;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_wid;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_idx;
  logic              unlock_valid;
  logic [WW-1:0]     unlock_wid;
  logic [31:0]       drain_stalls;

  csr_req_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_wid(out_wid), .out_addr(out_addr), .out_data(out_data),
    .out_idx(out_idx), .unlock_valid(unlock_valid), .unlock_wid(unlock_wid),
    .drain_stalls(drain_stalls)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int xfers  = 0;
  int unlocks = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) xfers = xfers + 1;
      if (unlock_valid) unlocks = unlocks + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [WW-1:0] w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req_wid[i*WW +: WW]  = w;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  typedef struct {
    logic [NR-1:0] rv;
    logic [NR-1:0] exp_ready;
    logic          exp_valid;
    logic [1:0]    exp_idx;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int x0;
    int u0;
    vecs[0]  = '{4'hF, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'hF, 4'b0000, 1'b1, 2'd0};
    vecs[2]  = '{4'hF, 4'b0010, 1'b0, 2'd0};
    vecs[3]  = '{4'hF, 4'b0000, 1'b1, 2'd1};
    vecs[4]  = '{4'hF, 4'b0100, 1'b0, 2'd0};
    vecs[5]  = '{4'hF, 4'b0000, 1'b1, 2'd2};
    vecs[6]  = '{4'hF, 4'b1000, 1'b0, 2'd0};
    vecs[7]  = '{4'hF, 4'b0000, 1'b1, 2'd3};
    vecs[8]  = '{4'hF, 4'b0001, 1'b0, 2'd0};
    vecs[9]  = '{4'hF, 4'b0000, 1'b1, 2'd0};
    vecs[10] = '{4'h0, 4'b0000, 1'b0, 2'd0};
    vecs[11] = '{4'h9, 4'b1000, 1'b0, 2'd0};
    vecs[12] = '{4'h0, 4'b0000, 1'b1, 2'd3};
    vecs[13] = '{4'h6, 4'b0010, 1'b0, 2'd0};
    vecs[14] = '{4'h0, 4'b0000, 1'b1, 2'd1};
    vecs[15] = '{4'h3, 4'b0001, 1'b0, 2'd0};
    vecs[16] = '{4'h0, 4'b0000, 1'b1, 2'd0};

    reset = 1'b1; req_valid = 4'hF; alm_empty = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_slot(i, WW'(i), 12'hC00, 64'hD0 + 64'(i));
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_unlock", 64'(unlock_valid), 64'h0);
    chk("reset_stalls", 64'(drain_stalls), 64'h0);
    chk("reset_alm_wid", 64'(alm_empty_wid), 64'h0);
    req_valid = 4'h0;
    reset = 1'b0;

    // Arbitration table: all addresses 12'hC00 (non-FPU), out_ready held high
    for (int r = 0; r < 17; r++) begin
      @(negedge clk);
      req_valid = vecs[r].rv;
      #1;
      chk($sformatf("rr_ready[%0d]", r), 64'(req_ready), 64'(vecs[r].exp_ready));
      chk($sformatf("rr_valid[%0d]", r), 64'(out_valid), 64'(vecs[r].exp_valid));
      chk($sformatf("rr_unlock[%0d]", r), 64'(unlock_valid), 64'h0);
      if (vecs[r].exp_valid) begin
        chk($sformatf("rr_idx[%0d]", r), 64'(out_idx), 64'(vecs[r].exp_idx));
        chk($sformatf("rr_wid[%0d]", r), 64'(out_wid), 64'(vecs[r].exp_idx));
        chk($sformatf("rr_data[%0d]", r), out_data, 64'hD0 + 64'(vecs[r].exp_idx));
        chk($sformatf("rr_addr[%0d]", r), 64'(out_addr), 64'hC00);
      end
    end

    // FPU drain: requester 2, wid 1, addr 003, alm_empty low for 3 cycles
    @(negedge clk);
    set_slot(2, 2'd1, 12'h003, 64'hFEED_0002);
    req_valid = 4'b0100; alm_empty = 1'b0;
    #1 chk("fpu_accept", 64'(req_ready), 64'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 4'h0;
      #1;
      chk($sformatf("fpu_drain_valid[%0d]", k), 64'(out_valid), 64'h0);
      chk($sformatf("fpu_drain_stalls[%0d]", k), 64'(drain_stalls), 64'(k));
      chk($sformatf("fpu_alm_wid[%0d]", k), 64'(alm_empty_wid), 64'h1);
      chk($sformatf("fpu_drain_ready[%0d]", k), 64'(req_ready), 64'h0);
    end
    @(negedge clk);
    alm_empty = 1'b1;
    #1;
    chk("fpu_stalls_3", 64'(drain_stalls), 64'h3);
    chk("fpu_not_yet_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    #1;
    chk("fpu_out_valid_t5", 64'(out_valid), 64'h1);
    chk("fpu_unlock", 64'(unlock_valid), 64'h1);
    chk("fpu_unlock_wid", 64'(unlock_wid), 64'h1);
    chk("fpu_out_idx", 64'(out_idx), 64'h2);
    chk("fpu_out_addr", 64'(out_addr), 64'h003);
    chk("fpu_out_data", out_data, 64'hFEED_0002);
    @(negedge clk);
    #1;
    chk("fpu_done_valid", 64'(out_valid), 64'h0);
    chk("fpu_done_unlock", 64'(unlock_valid), 64'h0);

    // Non-FPU boundary: addr 004 goes straight to SEND even with alm_empty low
    @(negedge clk);
    set_slot(0, 2'd2, 12'h004, 64'hABCD);
    req_valid = 4'b0001; alm_empty = 1'b0;
    #1 chk("nfpu_accept", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    chk("nfpu_valid_t1", 64'(out_valid), 64'h1);
    chk("nfpu_unlock", 64'(unlock_valid), 64'h0);
    chk("nfpu_addr", 64'(out_addr), 64'h004);
    chk("nfpu_stalls", 64'(drain_stalls), 64'h3);

    // Backpressure: out_ready low for 4 cycles in SEND, other requesters keep asking
    @(negedge clk);
    set_slot(1, 2'd3, 12'h300, 64'h1234_5678);
    req_valid = 4'b0010; out_ready = 1'b0;
    #1 chk("bp_accept", 64'(req_ready), 64'b0010);
    x0 = xfers;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk($sformatf("bp_valid[%0d]", k), 64'(out_valid), 64'h1);
      chk($sformatf("bp_ready[%0d]", k), 64'(req_ready), 64'h0);
      chk($sformatf("bp_wid[%0d]", k), 64'(out_wid), 64'h3);
      chk($sformatf("bp_addr[%0d]", k), 64'(out_addr), 64'h300);
      chk($sformatf("bp_data[%0d]", k), out_data, 64'h1234_5678);
      chk($sformatf("bp_idx[%0d]", k), 64'(out_idx), 64'h1);
    end
    @(negedge clk);
    out_ready = 1'b1; req_valid = 4'h0;
    #1 chk("bp_release_valid", 64'(out_valid), 64'h1);
    @(negedge clk);
    #1;
    chk("bp_after_valid", 64'(out_valid), 64'h0);
    chk("bp_one_xfer", 64'(xfers - x0), 64'h1);

    // Reset during DRAIN drops the held FPU request
    @(negedge clk);
    set_slot(2, 2'd2, 12'h001, 64'h77);
    req_valid = 4'b0100; alm_empty = 1'b0;
    #1 chk("rst_accept", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = 4'h0;
    #1 chk("rst_alm_wid", 64'(alm_empty_wid), 64'h2);
    @(negedge clk);
    u0 = unlocks;
    reset = 1'b1; alm_empty = 1'b1; req_valid = 4'hF;
    #1 chk("rst_pre_stalls", 64'(drain_stalls), 64'h4);
    @(negedge clk);
    #1;
    chk("rst_cycle_ready", 64'(req_ready), 64'h0);
    chk("rst_cycle_valid", 64'(out_valid), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_slot(i, WW'(3 - i), 12'h002, 64'(i));
    alm_empty = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_unlock", 64'(unlock_valid), 64'h0);
    chk("rst_stalls", 64'(drain_stalls), 64'h0);
    chk("rst_alm_wid0", 64'(alm_empty_wid), 64'h0);
    chk("rst_rr_ptr0", 64'(req_ready), 64'b0001);

    // Saturation: preload the stall counter just below its maximum during a long DRAIN
    @(negedge clk);
    req_valid = 4'h0;
    force dut.stall_cnt_p1 = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_p1;
    @(negedge clk);
    #1 chk("sat_fe", 64'(drain_stalls), 64'hFFFF_FFFE);
    @(negedge clk);
    #1 chk("sat_ff", 64'(drain_stalls), 64'hFFFF_FFFF);
    @(negedge clk);
    #1 chk("sat_hold", 64'(drain_stalls), 64'hFFFF_FFFF);
    alm_empty = 1'b1;
    @(negedge clk);
    #1;
    chk("sat_send_valid", 64'(out_valid), 64'h1);
    chk("sat_unlock", 64'(unlock_valid), 64'h1);
    chk("sat_unlock_wid", 64'(unlock_wid), 64'h3);
    chk("sat_final", 64'(drain_stalls), 64'hFFFF_FFFF);
    @(negedge clk);
    #1 chk("rst_no_stray_unlock", 64'(unlocks - u0), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_req_scheduler.md
# csr_req_scheduler

- Sits in front of the core's single CSR execution unit and shares it among `NUM_REQS` issue-slice requesters using round-robin arbitration.
- For FPU CSR accesses (address ≤ `FCSR_ADDR`), waits until the target warp has no pending instructions before issuing, then raises a one-cycle unlock to the scheduler when the request is handed off.
- Holds one request at a time in a skid register, so issue to the CSR unit uses a registered valid/ready handshake.

## Interface

Reset is synchronous and active-high. There is one clock.

Parameters:
- `NUM_REQS`, default 4: number of requesters; must be ≥ 2.
- `WID_W`, default 2: warp-id width.
- `ADDR_W`, default 12: CSR address width.
- `DATAW`, default 64: opaque payload width (uuid, tmask, PC, rd, operands); passed through untouched.
- `FCSR_ADDR`, default 12'h003: highest FPU CSR address.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQS`: per-requester request valid.
- `req_wid` in `NUM_REQS*WID_W`: per-requester warp id.
- `req_addr` in `NUM_REQS*ADDR_W`: per-requester CSR address.
- `req_data` in `NUM_REQS*DATAW`: per-requester payload.
- `req_ready` out `NUM_REQS`: one-hot grant/accept.
- `alm_empty_wid` out `WID_W`: warp being queried for drain.
- `alm_empty` in 1: the queried warp has no pending instructions.
- `out_valid` out 1: request valid to the CSR unit.
- `out_ready` in 1: CSR unit accepts the request.
- `out_wid` out `WID_W`, `out_addr` out `ADDR_W`, `out_data` out `DATAW`, `out_idx` out `clog2(NUM_REQS)`: held request fields.
- `unlock_valid` out 1: one-cycle unlock pulse for an FPU CSR warp.
- `unlock_wid` out `WID_W`: warp to unlock.
- `drain_stalls` out 32: saturating count of drain-wait cycles.

## Operation

The state machine has three states: IDLE, DRAIN and SEND.

**IDLE**
- Grant the first asserted `req_valid` found searching from `rr_ptr` upward, modulo `NUM_REQS`.
- `req_ready[g]` = 1, combinationally, only in IDLE and only for the granted index. The handshake completes in that cycle.
- On a grant:
  - Latch wid, addr, data and index into the hold register.
  - Set `is_fpu` = (addr ≤ `FCSR_ADDR`), unsigned compare.
  - Set `rr_ptr` ← (g+1) mod `NUM_REQS`.
- Next state: DRAIN if `is_fpu`, else SEND.
- With no request pending, stay in IDLE and leave `rr_ptr` unchanged.

**DRAIN**
- If `alm_empty` = 1, go to SEND next cycle.
- Otherwise stay in DRAIN and increment `drain_stalls`, saturating at 32'hFFFFFFFF.

**SEND**
- `out_valid` = 1 and all `out_*` fields are driven from the hold register.
- On `out_valid && out_ready`, return to IDLE.
- In that same handshake cycle, `unlock_valid` = `is_fpu` and `unlock_wid` = held wid.
- `out_*` are stable while `out_valid && !out_ready`.

**Always**
- `alm_empty_wid` = held wid, in every state.
- `req_ready` = 0 in DRAIN and SEND. No new request is accepted until the held request is handed off.

## Timing

Reset:
- `state` = IDLE, `rr_ptr` = 0, hold register = 0, `drain_stalls` = 0.
- `out_valid`, `unlock_valid` and `req_ready` = 0 in the reset cycle.

Latency:
- Non-FPU: accepted at cycle T gives `out_valid` at T+1.
- FPU: accepted at T gives DRAIN at T+1. With `alm_empty` low for k cycles, `out_valid` is at T+2+k, so the minimum is T+2.

Throughput:
- At most one request per 2 cycles (IDLE→SEND→IDLE).
- With back-to-back `out_ready` = 1, a non-FPU stream sustains 50%.

Boundary conditions:
- **All requesters valid:** grants rotate, so each requester is served once per `NUM_REQS` grants.
- **`rr_ptr` wrap:** a grant at index `NUM_REQS-1` sets `rr_ptr` = 0.
- **Address = `FCSR_ADDR`:** treated as FPU. `FCSR_ADDR`+1 is non-FPU.
- **Reset mid-DRAIN or mid-SEND:** the held request is dropped and no `unlock_valid` is generated.
- **`drain_stalls` at max:** holds at its maximum value.
- **`req_valid` dropping without a grant:** legal; nothing is latched.

## Test plan

1. **Round-robin rotation.** Reset; hold all 4 `req_valid` = 1 with `out_ready` = 1, all addresses 12'hC00. Required: grants go to requesters 0,1,2,3,0,…, with `out_valid` every other cycle, and `out_idx` follows the same sequence.
2. **FPU drain.** Requester 2 sends wid = 1, addr = 12'h003, with `alm_empty` = 0 for 3 cycles then 1. Required:
   - `alm_empty_wid` = 1.
   - `drain_stalls` = 3.
   - `out_valid` 5 cycles after the accept.
   - `unlock_valid` = 1 with `unlock_wid` = 1 in the handshake cycle.
3. **Non-FPU boundary.** addr = 12'h004 with `alm_empty` = 0. Required: `out_valid` at T+1 regardless of `alm_empty`, `unlock_valid` never asserts, and `drain_stalls` is unchanged.
4. **Output backpressure.** Hold `out_ready` = 0 for 4 cycles in SEND. Required: `out_*` stable, all `req_ready` = 0, and exactly one transfer once `out_ready` = 1.
5. **Reset mid-operation.** Assert `reset` during DRAIN. Required: the next cycle is IDLE with `rr_ptr` = 0, `out_valid` = 0, no unlock pulse, and `drain_stalls` = 0.
6. **Saturation.** Force `drain_stalls` near its maximum, e.g. via a long DRAIN using a preloaded value in simulation. Required: it stops at 32'hFFFFFFFF without wrapping.
